// File: rtl/game_countdown.sv
// Level countdown timer: keeps remaining time as BCD mm:ss, advanced by edges of the 1 s divider output,
// with start/pause/bonus control and low-time / expiry flags for the game FSM.
module game_countdown #(
    parameter int START_MIN = 3,
    parameter int START_SEC = 0,
    parameter int BONUS_SEC = 5,
    parameter int WARN_SEC  = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_1s,
    input  logic       start,
    input  logic       pause,
    input  logic       add_bonus,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic       running,
    output logic       paused,
    output logic       warn,
    output logic       expired,
    output logic       time_up
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RUN     = 2'd1;
    localparam logic [1:0] ST_PAUSE   = 2'd2;
    localparam logic [1:0] ST_EXPIRED = 2'd3;

    localparam logic [15:0] START_BCD = 16'(((START_MIN / 32'd10) * 32'd4096) + ((START_MIN % 32'd10) * 32'd256)
                                         + ((START_SEC / 32'd10) * 32'd16) + (START_SEC % 32'd10));
    localparam logic [1:0]  LOAD_ST   = (START_BCD == 16'h0000) ? ST_EXPIRED : ST_RUN;

    function automatic logic [6:0] bcd_to_bin(input logic [7:0] b);
        return (7'(b[7:4]) * 7'd10) + 7'(b[3:0]);
    endfunction

    function automatic logic [7:0] bin_to_bcd(input logic [6:0] v);
        return {4'(v / 7'd10), 4'(v % 7'd10)};
    endfunction

    function automatic logic [7:0] bcd_inc(input logic [7:0] b);
        logic [7:0] r;
        if (b[3:0] == 4'd9) begin
            r = {b[7:4] + 4'd1, 4'd0};
        end else begin
            r = {b[7:4], b[3:0] + 4'd1};
        end
        return r;
    endfunction

    // Per-digit borrow chain; caller guarantees the value is not 00:00
    function automatic logic [15:0] bcd_dec(input logic [15:0] t);
        logic [3:0] mt, mo, st, so;
        {mt, mo, st, so} = t;
        if (so != 4'd0) begin
            so = so - 4'd1;
        end else begin
            so = 4'd9;
            if (st != 4'd0) begin
                st = st - 4'd1;
            end else begin
                st = 4'd5;
                if (mo != 4'd0) begin
                    mo = mo - 4'd1;
                end else begin
                    mo = 4'd9;
                    mt = mt - 4'd1;
                end
            end
        end
        return {mt, mo, st, so};
    endfunction

    function automatic logic [15:0] bcd_add_bonus(input logic [15:0] t);
        logic [6:0]  sum;
        logic [15:0] r;
        sum = bcd_to_bin(t[7:0]) + 7'(BONUS_SEC);
        if (sum >= 7'd60) begin
            if (t[15:8] == 8'h99) begin
                r = 16'h9959;
            end else begin
                r = {bcd_inc(t[15:8]), bin_to_bcd(sum - 7'd60)};
            end
        end else begin
            r = {t[15:8], bin_to_bcd(sum)};
        end
        return r;
    endfunction

    logic        s1_r, s2_r, s3_r;
    logic        tick_s;
    logic [1:0]  state_r, state_s;
    logic [15:0] cnt_r, cnt_s, bonus_s, dec_s;
    logic        warn_s;

    assign tick_s  = s2_r ^ s3_r;
    assign min_bcd = cnt_r[15:8];
    assign sec_bcd = cnt_r[7:0];

    // Synchronise clk_1s and keep a delayed copy for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_r <= 1'b0;
            s2_r <= 1'b0;
            s3_r <= 1'b0;
        end else begin
            s1_r <= clk_1s;
            s2_r <= s1_r;
            s3_r <= s2_r;
        end
    end

    // Next state and count; bonus is folded in before any decrement
    always_comb begin
        bonus_s = add_bonus ? bcd_add_bonus(cnt_r) : cnt_r;
        dec_s   = (bonus_s != 16'h0000) ? bcd_dec(bonus_s) : bonus_s;
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    cnt_s   = START_BCD;
                    state_s = LOAD_ST;
                end else begin
                    cnt_s   = cnt_r;
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (start) begin
                    cnt_s   = START_BCD;
                    state_s = LOAD_ST;
                end else if (pause) begin
                    cnt_s   = bonus_s;
                    state_s = ST_PAUSE;
                end else if (tick_s && (bonus_s != 16'h0000)) begin
                    cnt_s   = dec_s;
                    state_s = (dec_s == 16'h0000) ? ST_EXPIRED : ST_RUN;
                end else begin
                    cnt_s   = bonus_s;
                    state_s = ST_RUN;
                end
            end
            ST_PAUSE: begin
                if (start) begin
                    cnt_s   = START_BCD;
                    state_s = LOAD_ST;
                end else begin
                    cnt_s   = bonus_s;
                    state_s = pause ? ST_RUN : ST_PAUSE;
                end
            end
            ST_EXPIRED: begin
                if (start) begin
                    cnt_s   = START_BCD;
                    state_s = LOAD_ST;
                end else begin
                    cnt_s   = 16'h0000;
                    state_s = ST_EXPIRED;
                end
            end
            default: begin
                cnt_s   = START_BCD;
                state_s = ST_IDLE;
            end
        endcase
        warn_s = ((state_s == ST_RUN) || (state_s == ST_PAUSE)) && (cnt_s[15:8] == 8'h00)
                 && (cnt_s[7:0] != 8'h00) && (bcd_to_bin(cnt_s[7:0]) <= 7'(WARN_SEC));
    end

    // State, count and flags all register together so they change in the same cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= START_BCD;
            running <= 1'b0;
            paused  <= 1'b0;
            warn    <= 1'b0;
            expired <= 1'b0;
            time_up <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            running <= (state_s == ST_RUN);
            paused  <= (state_s == ST_PAUSE);
            warn    <= warn_s;
            expired <= (state_s == ST_EXPIRED);
            time_up <= (state_s == ST_EXPIRED) && (state_r != ST_EXPIRED);
        end
    end

endmodule

// File: tb/tb_game_countdown.sv
// Directed bench for game_countdown: five instances with different start times share clk_1s and rst.
module tb_game_countdown;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clk_1s = 1'b0;
    logic start_a = 1'b0, pause_a = 1'b0, bonus_a = 1'b0;
    logic start_x = 1'b0, pause_x = 1'b0, bonus_x = 1'b0;

    // index 0: 00:12, 1: 02:00, 2: 10:00, 3: 99:57, 4: 00:00
    logic [7:0] min_o [5];
    logic [7:0] sec_o [5];
    logic       run_o [5];
    logic       pau_o [5];
    logic       warn_o [5];
    logic       exp_o [5];
    logic       tu_o [5];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    game_countdown #(.START_MIN(0), .START_SEC(12), .BONUS_SEC(5), .WARN_SEC(10)) u_a (
        .clk(clk), .rst(rst), .clk_1s(clk_1s), .start(start_a), .pause(pause_a), .add_bonus(bonus_a),
        .min_bcd(min_o[0]), .sec_bcd(sec_o[0]), .running(run_o[0]), .paused(pau_o[0]),
        .warn(warn_o[0]), .expired(exp_o[0]), .time_up(tu_o[0]));
    game_countdown #(.START_MIN(2), .START_SEC(0), .BONUS_SEC(5), .WARN_SEC(10)) u_b (
        .clk(clk), .rst(rst), .clk_1s(clk_1s), .start(start_x), .pause(pause_x), .add_bonus(bonus_x),
        .min_bcd(min_o[1]), .sec_bcd(sec_o[1]), .running(run_o[1]), .paused(pau_o[1]),
        .warn(warn_o[1]), .expired(exp_o[1]), .time_up(tu_o[1]));
    game_countdown #(.START_MIN(10), .START_SEC(0), .BONUS_SEC(5), .WARN_SEC(10)) u_c (
        .clk(clk), .rst(rst), .clk_1s(clk_1s), .start(start_x), .pause(pause_x), .add_bonus(bonus_x),
        .min_bcd(min_o[2]), .sec_bcd(sec_o[2]), .running(run_o[2]), .paused(pau_o[2]),
        .warn(warn_o[2]), .expired(exp_o[2]), .time_up(tu_o[2]));
    game_countdown #(.START_MIN(99), .START_SEC(57), .BONUS_SEC(5), .WARN_SEC(10)) u_d (
        .clk(clk), .rst(rst), .clk_1s(clk_1s), .start(start_x), .pause(pause_x), .add_bonus(bonus_x),
        .min_bcd(min_o[3]), .sec_bcd(sec_o[3]), .running(run_o[3]), .paused(pau_o[3]),
        .warn(warn_o[3]), .expired(exp_o[3]), .time_up(tu_o[3]));
    game_countdown #(.START_MIN(0), .START_SEC(0), .BONUS_SEC(5), .WARN_SEC(10)) u_z (
        .clk(clk), .rst(rst), .clk_1s(clk_1s), .start(start_x), .pause(pause_x), .add_bonus(bonus_x),
        .min_bcd(min_o[4]), .sec_bcd(sec_o[4]), .running(run_o[4]), .paused(pau_o[4]),
        .warn(warn_o[4]), .expired(exp_o[4]), .time_up(tu_o[4]));

    task automatic clk_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic toggle;
        clk_1s = ~clk_1s;
        clk_n(3);
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int n);
        return 8'(((n / 10) * 16) + (n % 10));
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset values
        clk_n(3);
        chk16("rst_a", {min_o[0], sec_o[0]}, 16'h0012);
        chk16("rst_d", {min_o[3], sec_o[3]}, 16'h9957);
        chk1("rst_run", run_o[0], 1'b0);
        chk1("rst_warn", warn_o[0], 1'b0);
        chk1("rst_exp", exp_o[0], 1'b0);
        chk1("rst_tu", tu_o[0], 1'b0);
        rst = 1'b0;
        clk_n(5);

        // Ticks in IDLE are ignored
        repeat (3) toggle();
        clk_n(2);
        chk16("idle_cnt", {min_o[0], sec_o[0]}, 16'h0012);
        chk1("idle_run", run_o[0], 1'b0);
        chk1("idle_exp", exp_o[0], 1'b0);

        // Full countdown from 00:12
        start_a = 1'b1; clk_n(1); start_a = 1'b0;
        chk1("start_run", run_o[0], 1'b1);
        chk16("start_cnt", {min_o[0], sec_o[0]}, 16'h0012);
        clk_1s = ~clk_1s;
        clk_n(2);
        chk16("lat_hold", {min_o[0], sec_o[0]}, 16'h0012);
        clk_n(1);
        chk16("lat_tick", {min_o[0], sec_o[0]}, 16'h0011);
        chk1("warn_11", warn_o[0], 1'b0);
        for (int n = 10; n >= 1; n--) begin
            toggle();
            chk16("cd_cnt", {min_o[0], sec_o[0]}, {8'h00, to_bcd(n)});
            chk1("cd_warn", warn_o[0], 1'b1);
            chk1("cd_tu", tu_o[0], 1'b0);
        end
        toggle();
        chk16("cd_zero", {min_o[0], sec_o[0]}, 16'h0000);
        chk1("tu_pulse", tu_o[0], 1'b1);
        chk1("exp_set", exp_o[0], 1'b1);
        chk1("exp_run", run_o[0], 1'b0);
        chk1("exp_warn", warn_o[0], 1'b0);
        clk_n(1);
        chk1("tu_once", tu_o[0], 1'b0);
        chk1("exp_hold", exp_o[0], 1'b1);
        repeat (2) toggle();
        chk16("exp_cnt", {min_o[0], sec_o[0]}, 16'h0000);
        chk1("exp_tu", tu_o[0], 1'b0);

        // Pause freezes the count
        rst = 1'b1; clk_n(1); rst = 1'b0; clk_n(5);
        start_a = 1'b1; clk_n(1); start_a = 1'b0;
        toggle();
        chk16("p_11", {min_o[0], sec_o[0]}, 16'h0011);
        pause_a = 1'b1; clk_n(1); pause_a = 1'b0;
        chk1("p_paused", pau_o[0], 1'b1);
        chk1("p_run", run_o[0], 1'b0);
        chk1("p_warn", warn_o[0], 1'b0);
        repeat (5) toggle();
        chk16("p_frozen", {min_o[0], sec_o[0]}, 16'h0011);
        chk1("p_still", pau_o[0], 1'b1);
        pause_a = 1'b1; clk_n(1); pause_a = 1'b0;
        chk1("r_run", run_o[0], 1'b1);
        chk1("r_paused", pau_o[0], 1'b0);
        toggle();
        chk16("r_10", {min_o[0], sec_o[0]}, 16'h0010);
        chk1("r_warn", warn_o[0], 1'b1);
        repeat (3) toggle();
        chk16("r_07", {min_o[0], sec_o[0]}, 16'h0007);

        // Asynchronous reset mid-run
        #2 rst = 1'b1;
        #1;
        chk16("mr_cnt", {min_o[0], sec_o[0]}, 16'h0012);
        chk1("mr_run", run_o[0], 1'b0);
        chk1("mr_warn", warn_o[0], 1'b0);
        chk1("mr_paused", pau_o[0], 1'b0);
        clk_n(2); rst = 1'b0; clk_n(5);
        start_a = 1'b1; pause_a = 1'b1; clk_n(1); start_a = 1'b0; pause_a = 1'b0;
        chk1("sp_run", run_o[0], 1'b1);
        chk1("sp_paused", pau_o[0], 1'b0);
        chk16("sp_cnt", {min_o[0], sec_o[0]}, 16'h0012);

        // Other start values: zero start, borrows, bonus and saturation
        rst = 1'b1; clk_n(1); rst = 1'b0; clk_n(5);
        start_x = 1'b1; clk_n(1); start_x = 1'b0;
        chk1("z_exp", exp_o[4], 1'b1);
        chk1("z_tu", tu_o[4], 1'b1);
        chk1("z_run", run_o[4], 1'b0);
        chk16("b_load", {min_o[1], sec_o[1]}, 16'h0200);
        chk16("c_load", {min_o[2], sec_o[2]}, 16'h1000);
        chk16("d_load", {min_o[3], sec_o[3]}, 16'h9957);
        clk_n(1);
        chk1("z_tu_once", tu_o[4], 1'b0);
        toggle();
        chk16("b_borrow", {min_o[1], sec_o[1]}, 16'h0159);
        chk16("c_borrow", {min_o[2], sec_o[2]}, 16'h0959);
        bonus_x = 1'b1; clk_n(1); bonus_x = 1'b0;
        chk16("d_sat", {min_o[3], sec_o[3]}, 16'h9959);
        chk16("b_bonus", {min_o[1], sec_o[1]}, 16'h0204);
        bonus_x = 1'b1; clk_n(1); bonus_x = 1'b0;
        chk16("d_sat2", {min_o[3], sec_o[3]}, 16'h9959);
        chk16("b_carry", {min_o[1], sec_o[1]}, 16'h0209);
        chk16("z_nobonus", {min_o[4], sec_o[4]}, 16'h0000);
        repeat (71) toggle();
        chk16("b_58", {min_o[1], sec_o[1]}, 16'h0058);
        clk_1s = ~clk_1s;
        clk_n(2);
        bonus_x = 1'b1; clk_n(1); bonus_x = 1'b0;
        chk16("b_add_tick", {min_o[1], sec_o[1]}, 16'h0102);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
